dmem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port, byte-addressable data memory between N requesters, e.g. the core load/store path on port 0 and a DMA/debug master on port 1. Each cycle it grants at most one request and drives the memory port from it. It registers the read data and returns it with a one-cycle response pulse. A bounded lock lets a requester hold the memory for back-to-back beats, such as a DMA burst, without starving the others.

---
 rtl/dmem_arbiter_if.sv | 31 +++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the single-port data memory.
// The slave view belongs to the arbiter. The master view belongs to the
// environment that drives the requests and models the memory.
interface dmem_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_lock;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    req_we;
  logic [N*4-1:0]  req_be;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_rdata;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [31:0]     mem_rdata;

  modport slave (
    input  req_valid, req_lock, req_addr, req_wdata, req_we, req_be, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_we, mem_be
  );

  modport master (
    output req_valid, req_lock, req_addr, req_wdata, req_we, req_be, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_we, mem_be
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between N requesters.
// At most one grant is made per cycle. A requester may hold the memory with a
// lock for at most MAX_LOCK consecutive grants. Read data comes back one cycle
// after acceptance, together with a one-hot response pulse.
module dmem_arbiter #(
  parameter int N        = 2,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic          lock_active;
  logic [7:0]    lock_cnt;

  logic          lock_hold;
  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;
  logic [7:0]    cnt_eff;
  logic          lock_go;

  logic [N-1:0]  rsp_valid_p1;
  logic [31:0]   rsp_rdata_p1;

  // Grant selection: a lock whose owner is still valid wins. Otherwise the
  // first valid index at or after rr_ptr, taken modulo N, wins.
  always_comb begin
    cand      = '0;
    lock_hold = lock_active && bus.req_valid[owner];
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    if (lock_hold) begin
      gnt_any = 1'b1;
      gnt_idx = owner;
    end else begin
      // Scan from the far end so that the candidate closest to rr_ptr is the
      // last one written, and therefore the one that wins.
      for (int k = N - 1; k >= 0; k--) begin
        cand = PW'((int'(rr_ptr) + k) % N);
        if (bus.req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // Lock decision for the current grant. If the owner has dropped its
  // request, the run count restarts from zero.
  always_comb begin
    cnt_eff = lock_hold ? lock_cnt : 8'd0;
    lock_go = gnt_any && bus.req_lock[gnt_idx] && ((int'(cnt_eff) + 1) < MAX_LOCK);
  end

  // Memory port drive and the one-hot ready. All outputs are zero when there is no grant.
  always_comb begin
    bus.req_ready = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    if (gnt_any) begin
      bus.req_ready[gnt_idx] = 1'b1;
      bus.mem_addr           = bus.req_addr[32*int'(gnt_idx) +: 32];
      bus.mem_wdata          = bus.req_wdata[32*int'(gnt_idx) +: 32];
      bus.mem_we             = bus.req_we[gnt_idx];
      bus.mem_be             = bus.req_be[4*int'(gnt_idx) +: 4];
    end
  end

  // Arbitration state: the round-robin pointer moves only when a grant ends
  // without keeping the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      owner       <= '0;
      lock_active <= 1'b0;
      lock_cnt    <= 8'd0;
    end else if (gnt_any) begin
      if (lock_go) begin
        lock_active <= 1'b1;
        owner       <= gnt_idx;
        lock_cnt    <= cnt_eff + 8'd1;
      end else begin
        lock_active <= 1'b0;
        lock_cnt    <= 8'd0;
        rr_ptr      <= PW'((int'(gnt_idx) + 1) % N);
      end
    end else begin
      lock_active <= 1'b0;
      lock_cnt    <= 8'd0;
    end
  end

  // Response stage (p1): one-cycle pulse for every accepted access. Read data
  // is captured only for reads, so writes leave the previous value in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_p1 <= '0;
      rsp_rdata_p1 <= '0;
    end else begin
      rsp_valid_p1 <= '0;
      if (gnt_any) begin
        rsp_valid_p1[gnt_idx] <= 1'b1;
        if (!bus.req_we[gnt_idx]) begin
          rsp_rdata_p1 <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_p1;
  assign bus.rsp_rdata = rsp_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. It runs directed scenarios and then a random
// phase. A small memory sits behind the arbiter. Every cycle the DUT is
// compared against a transaction-level reference model that keeps its own
// shadow copy of the memory.
module tb_dmem_arbiter;
  localparam int N        = 3;
  localparam int MAX_LOCK = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.N(N)) bus();

  dmem_arbiter #(.N(N), .MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory behind the arbiter: combinational read, byte-enabled write on the edge.
  logic [31:0] mem [0:63];
  logic        mem_init = 1'b1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'h0000_0000;
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  // Reference model state
  int          m_ptr;
  int          m_owner;
  int          m_streak;
  logic [N-1:0] exp_rsp_valid;
  logic [31:0] exp_rdata;
  logic [31:0] ref_mem [0:63];
  int          last_g;
  logic [N-1:0] obs_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_ptr         = 0;
    m_owner       = -1;
    m_streak      = 0;
    exp_rsp_valid = '0;
    exp_rdata     = '0;
    last_g        = -1;
  endtask

  // A live lock owner wins. Otherwise the first valid requester from the
  // priority pointer onward wins. The result is -1 when nobody is asking.
  function automatic int model_grant();
    if (m_owner >= 0 && bus.req_valid[m_owner]) return m_owner;
    for (int k = 0; k < N; k++)
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_update(input int g);
    int w;
    int streak;
    exp_rsp_valid = '0;
    if (g < 0) begin
      m_owner  = -1;
      m_streak = 0;
      return;
    end
    exp_rsp_valid[g] = 1'b1;
    w = int'(bus.req_addr[32*g+2 +: 6]);
    if (bus.req_we[g]) begin
      for (int b = 0; b < 4; b++)
        if (bus.req_be[4*g+b]) ref_mem[w][8*b +: 8] = bus.req_wdata[32*g+8*b +: 8];
    end else begin
      exp_rdata = ref_mem[w];
    end
    // A locked requester gets at most MAX_LOCK grants in a row.
    streak = (m_owner == g) ? m_streak + 1 : 1;
    if (bus.req_lock[g] && streak < MAX_LOCK) begin
      m_owner  = g;
      m_streak = streak;
    end else begin
      m_owner  = -1;
      m_streak = 0;
      m_ptr    = (g + 1) % N;
    end
  endtask

  // One clock cycle: compare the DUT against the model at the falling edge,
  // advance the model, then return 1 time unit after the rising edge.
  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g       = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_rdy = bus.req_ready;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("mem_we",    32'(bus.mem_we),    (g >= 0) ? 32'(bus.req_we[g]) : 32'd0);
    chk("mem_be",    32'(bus.mem_be),    (g >= 0) ? 32'(bus.req_be[4*g +: 4]) : 32'd0);
    chk("mem_addr",  bus.mem_addr,       (g >= 0) ? bus.req_addr[32*g +: 32] : 32'd0);
    chk("mem_wdata", bus.mem_wdata,      (g >= 0) ? bus.req_wdata[32*g +: 32] : 32'd0);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp_valid));
    chk("rsp_rdata", bus.rsp_rdata,      exp_rdata);
    last_g = g;
    model_update(g);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bus.req_valid[i]          = v;
    bus.req_lock[i]           = l;
    bus.req_we[i]             = w;
    bus.req_addr[32*i +: 32]  = a;
    bus.req_wdata[32*i +: 32] = d;
    bus.req_be[4*i +: 4]      = b;
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
  endtask

  task automatic do_reset();
    clear_all();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    @(posedge clk);
    #1;
  endtask

  int lock_seq [6] = '{0, 1, 1, 1, 1, 0};

  initial begin
    logic [31:0] one;
    one = 32'd1;
    clear_all();
    reset_model();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",     32'(bus.req_ready), 32'd0);
    chk("reset_mem_we",    32'(bus.mem_we),    32'd0);
    chk("reset_mem_be",    32'(bus.mem_be),    32'd0);
    chk("reset_mem_addr",  bus.mem_addr,       32'd0);
    chk("reset_mem_wdata", bus.mem_wdata,      32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata,      32'd0);
    mem_init = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    // Single read from 0x10
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
    step();
    chk("single_ready", 32'(obs_rdy), 32'd1);
    clear_all();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    step();
    chk("single_pulse_end", 32'(bus.rsp_valid), 32'd0);

    // Contention between ports 0 and 1 from reset, without locks
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_order", 32'(obs_rdy), one << (i % 2));
      chk("rr_rsp",   32'(bus.rsp_valid), one << (i % 2));
    end

    // Lock cap: port 1 keeps its grant for MAX_LOCK cycles, then yields
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h4C, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lock_seq", 32'(obs_rdy), one << lock_seq[i]);
    end

    // Byte-enabled write, then read back
    clear_all();
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'b0101);
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
    step();
    clear_all();
    chk("bytewr_rdata", bus.rsp_rdata, 32'h00220044);

    // Idle cycle, then a write response on port 1
    step();
    chk("idle_mem_we", 32'(bus.mem_we), 32'd0);
    chk("idle_mem_be", 32'(bus.mem_be), 32'd0);
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    step();
    clear_all();
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd2);
    chk("wr_rdata_hold", bus.rsp_rdata, 32'h00220044);

    // Asynchronous reset while port 1 holds a lock and a response is pending
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h34, 32'h0, 4'hF);
    step();
    chk("pre_rst_rsp", 32'(bus.rsp_valid), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h54, 32'h0, 4'hF);
    step();
    chk("rst_first_grant", 32'(obs_rdy), 32'd1);

    // Random traffic. A request that has not been accepted yet is held stable.
    clear_all();
    last_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || last_g == i) begin
          set_req(i,
                  ($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 4),
                  {24'd0, 6'($urandom), 2'b00},
                  $urandom,
                  4'($urandom));
        end
      end
      step();
    end
    clear_all();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
